instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the 16-bit single-issue core. Owns the PC, fetches from instruction memory over a
//  req/ack handshake, and holds the IF/ID register. That register supplies if_opcode to the opcode decoder.
//  Resolves jump/beq/bne redirects raised by the execute stage and flushes wrong-path fetches.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
//  NOP_INSTR  16'h0000  value driven on if_instr while if_valid=0
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  imem_req      out  1   fetch request; held with stable imem_addr until imem_ack
//  imem_addr     out  16  word address of the requested instruction
//  imem_ack      in   1   one-cycle pulse, imem_rdata valid; may arrive same cycle as req
//  imem_rdata    in   16  fetched instruction
//  id_stall      in   1   decode cannot accept; IF/ID holds
//  ex_jump       in   1   execute-stage jump
//  ex_beq        in   1   execute-stage branch-if-equal
//  ex_bne        in   1   execute-stage branch-if-not-equal
//  ex_zero       in   1   ALU zero flag of the branch compare
//  ex_pc_plus1   in   16  PC+1 of the instruction in execute
//  ex_imm        in   6   branch offset, instr[5:0], signed words
//  ex_jtarget    in   12  jump target field, instr[11:0]
//  if_valid      out  1   IF/ID holds a real instruction
//  if_instr      out  16  IF/ID instruction
//  if_opcode     out  4   if_instr[15:12], to decoder
//  if_pc_plus1   out  16  PC+1 of the IF/ID instruction
//  flush         out  1   one-cycle pulse: redirect taken this cycle
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - pc=RESET_PC, state=FETCH, if_valid=0, if_instr=NOP_INSTR, if_pc_plus1=0, skid empty, flush=0.
//  - imem_req=0 while reset_n=0. It rises the first cycle after release.
//  redirect = ex_jump | (ex_beq & ex_zero) | (ex_bne & ~ex_zero). If several are set, jump wins.
//  Targets, all 16-bit with wrap-around:
//  - branch = ex_pc_plus1 + sext(ex_imm)
//  - jump = {ex_pc_plus1[15:12], ex_jtarget}
//  Consume = if_valid & ~id_stall.
//  IF/ID is free when ~if_valid or consume.
//  Registered FSM, 2-bit state:
//  - FETCH: imem_req=1, imem_addr=pc.
//    - ack with IF/ID free: load IF/ID with rdata and pc+1, set if_valid, pc<=pc+1, stay. Throughput is 1 instr/cycle.
//    - ack with IF/ID blocked: write skid {rdata, pc+1}, pc<=pc+1, go to HOLD.
//    - No ack while IF/ID is consumed: clear if_valid.
//  - HOLD: imem_req=0. When IF/ID is free, move skid into IF/ID and go to FETCH.
//  - DRAIN: imem_req=1 with the old address until ack. Discard the data, then go to FETCH.
//  Redirect has priority over every other event:
//  - pc<=target, if_valid<=0, skid cleared, flush=1.
//  - Next state is DRAIN if a req is outstanding and no ack arrives this cycle. Otherwise (ack this cycle, or HOLD) FETCH.
//  - A redirect arriving in DRAIN updates pc and stays in DRAIN.
//  - id_stall is ignored for the flush. The flushed slot becomes if_valid=0.
//  Invariants:
//  - imem_addr never changes while imem_req=1 and no ack has arrived.
//  - At most one request is outstanding.
//  - if_instr = NOP_INSTR whenever if_valid=0.
//  - if_opcode is always if_instr[15:12].
//  Reset mid-request: the outstanding fetch is abandoned. The memory side must tolerate req dropping.
// STRUCTURE
//  Shared package core_pkg:
//  - OPC_LW/SW/RTYPE/BEQ/BNE/JMP 4-bit opcode constants, INSTR_W=16, PC_W=16, NOP_INSTR.
//  - Fetch state encoding FS_FETCH/FS_HOLD/FS_DRAIN.
//  Sub-module next_pc_sel: combinational redirect and target computation, reusable by the branch unit.
//  Top: FSM, PC register, skid register, IF/ID register.
// TESTING
//  1. Reset, zero-latency memory (ack same cycle) returning 16'h1234 at addr 0.
//     -> imem_addr=0 first cycle; if_valid=1, if_opcode=4'h1, if_pc_plus1=1 next cycle.
//     -> Addresses 0,1,2,3 on consecutive cycles.
//  2. id_stall=1 for 3 cycles with an ack pending.
//     -> Skid captures the word, state HOLD, imem_req=0.
//     -> After stall drops: the skid word appears, then fetch resumes at the next address. No instruction lost or duplicated.
//  3. ex_beq=1, ex_zero=1, ex_pc_plus1=16'h0010, ex_imm=6'h3E (-2).
//     -> flush=1, if_valid=0, next imem_addr=16'h000E.
//     -> Repeat with ex_zero=0: no redirect.
//  4. ex_jump=1, ex_pc_plus1=16'hA005, ex_jtarget=12'h123.
//     -> next imem_addr=16'hA123.
//     -> With ex_beq also true, the jump target still wins.
//  5. 3-cycle memory latency, redirect to 16'h0040 one cycle after req at 16'h0008.
//     -> imem_addr stays 8 until ack; that data is dropped (if_valid=0); next req addr=16'h0040.
//  6. pc=16'hFFFF fetch -> next addr 16'h0000.
//     -> reset_n asserted mid-wait: all outputs go to their reset values immediately.
//     -> First fetch after release is at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit single-issue core: widths, opcodes, fetch FSM encoding.
package core_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Major opcodes carried in instr[15:12]
  localparam logic [3:0] OPC_RTYPE = 4'h0;
  localparam logic [3:0] OPC_LW    = 4'h1;
  localparam logic [3:0] OPC_SW    = 4'h2;
  localparam logic [3:0] OPC_BEQ   = 4'h3;
  localparam logic [3:0] OPC_BNE   = 4'h4;
  localparam logic [3:0] OPC_JMP   = 4'h5;

  // Fetch FSM: FETCH requests at pc, HOLD parks a word in the skid,
  // DRAIN waits out a wrong-path request and drops its data.
  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_HOLD  = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Redirect decision and target address for jump/beq/bne resolved in execute.
module next_pc_sel
  import core_pkg::*;
(
  input  logic            i_jump,
  input  logic            i_beq,
  input  logic            i_bne,
  input  logic            i_zero,
  input  logic [PC_W-1:0] i_pc_plus1,
  input  logic [5:0]      i_imm,
  input  logic [11:0]     i_jtarget,
  output logic            o_redirect,
  output logic [PC_W-1:0] o_target
);

  logic [PC_W-1:0] w_branch_tgt;
  logic [PC_W-1:0] w_jump_tgt;

  assign w_branch_tgt = i_pc_plus1 + {{(PC_W-6){i_imm[5]}}, i_imm};
  assign w_jump_tgt   = {i_pc_plus1[15:12], i_jtarget};

  // Jump takes precedence over any branch raised in the same cycle
  always_comb begin
    o_redirect = i_jump | (i_beq & i_zero) | (i_bne & ~i_zero);
    o_target   = i_jump ? w_jump_tgt : w_branch_tgt;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack fetch FSM with one-entry skid, IF/ID register, redirect/flush.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        id_stall,
  input  logic        ex_jump,
  input  logic        ex_beq,
  input  logic        ex_bne,
  input  logic        ex_zero,
  input  logic [15:0] ex_pc_plus1,
  input  logic [5:0]  ex_imm,
  input  logic [11:0] ex_jtarget,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [3:0]  if_opcode,
  output logic [15:0] if_pc_plus1,
  output logic        flush
);

  fetch_state_e r_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_addr;
  logic         r_req;
  logic         r_flush;
  logic         r_if_valid;
  logic [15:0]  r_if_instr;
  logic [15:0]  r_if_pc1;
  logic [15:0]  r_skid_instr;
  logic [15:0]  r_skid_pc1;

  logic         w_redirect;
  logic [15:0]  w_target;
  logic         w_ack;
  logic         w_consume;
  logic         w_if_free;
  logic [15:0]  w_pc_plus1;

  fetch_state_e w_nxt_state;
  logic [15:0]  w_nxt_pc;
  logic         w_nxt_if_valid;
  logic [15:0]  w_nxt_if_instr;
  logic [15:0]  w_nxt_if_pc1;
  logic [15:0]  w_nxt_skid_instr;
  logic [15:0]  w_nxt_skid_pc1;

  next_pc_sel u_next_pc_sel (
    .i_jump     (ex_jump),
    .i_beq      (ex_beq),
    .i_bne      (ex_bne),
    .i_zero     (ex_zero),
    .i_pc_plus1 (ex_pc_plus1),
    .i_imm      (ex_imm),
    .i_jtarget  (ex_jtarget),
    .o_redirect (w_redirect),
    .o_target   (w_target)
  );

  // An ack only counts against a request we actually have outstanding
  assign w_ack      = imem_ack & r_req;
  assign w_consume  = r_if_valid & ~id_stall;
  assign w_if_free  = ~r_if_valid | w_consume;
  assign w_pc_plus1 = r_pc + 16'd1;

  // Next-state logic: redirect overrides every fetch/hold/drain event
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_pc         = r_pc;
    w_nxt_if_valid   = r_if_valid;
    w_nxt_if_instr   = r_if_instr;
    w_nxt_if_pc1     = r_if_pc1;
    w_nxt_skid_instr = r_skid_instr;
    w_nxt_skid_pc1   = r_skid_pc1;
    if (w_redirect) begin
      w_nxt_pc       = w_target;
      w_nxt_if_valid = 1'b0;
      w_nxt_if_instr = NOP_INSTR;
      // A still-open request must be drained so its wrong-path data is dropped
      w_nxt_state    = (r_req && !w_ack) ? FS_DRAIN : FS_FETCH;
    end else begin
      case (r_state)
        FS_FETCH: begin
          if (w_ack) begin
            w_nxt_pc = w_pc_plus1;
            if (w_if_free) begin
              w_nxt_if_valid = 1'b1;
              w_nxt_if_instr = imem_rdata;
              w_nxt_if_pc1   = w_pc_plus1;
            end else begin
              w_nxt_skid_instr = imem_rdata;
              w_nxt_skid_pc1   = w_pc_plus1;
              w_nxt_state      = FS_HOLD;
            end
          end else if (w_consume) begin
            w_nxt_if_valid = 1'b0;
            w_nxt_if_instr = NOP_INSTR;
          end
        end
        FS_HOLD: begin
          if (w_if_free) begin
            w_nxt_if_valid = 1'b1;
            w_nxt_if_instr = r_skid_instr;
            w_nxt_if_pc1   = r_skid_pc1;
            w_nxt_state    = FS_FETCH;
          end
        end
        FS_DRAIN: begin
          if (w_consume) begin
            w_nxt_if_valid = 1'b0;
            w_nxt_if_instr = NOP_INSTR;
          end
          if (w_ack) w_nxt_state = FS_FETCH;
        end
        default: w_nxt_state = FS_FETCH;
      endcase
    end
  end

  // State, PC, skid, IF/ID and registered memory-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= FS_FETCH;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_req        <= 1'b0;
      r_flush      <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= NOP_INSTR;
      r_if_pc1     <= 16'h0000;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc1   <= 16'h0000;
    end else begin
      r_state      <= w_nxt_state;
      r_pc         <= w_nxt_pc;
      // In DRAIN the old address stays on the bus until its ack
      r_addr       <= (w_nxt_state == FS_DRAIN) ? r_addr : w_nxt_pc;
      r_req        <= (w_nxt_state != FS_HOLD);
      r_flush      <= w_redirect;
      r_if_valid   <= w_nxt_if_valid;
      r_if_instr   <= w_nxt_if_instr;
      r_if_pc1     <= w_nxt_if_pc1;
      r_skid_instr <= w_nxt_skid_instr;
      r_skid_pc1   <= w_nxt_skid_pc1;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign flush       = r_flush;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_opcode   = r_if_instr[15:12];
  assign if_pc_plus1 = r_if_pc1;

endmodule
